// File: rtl/rv32i_regfile_mp.sv
// rv32i_regfile_mp: multi-port register file with busy scoreboard and sequential clear engine
// Ports: clk/rst (async active-high); clear_req starts a sequential clear; ready=1 once storage is zeroed.
// rd_addr/rd_data/rd_busy: NRD combinational read ports. wr_en/wr_addr/wr_data: NWR write ports.
// rsv_en/rsv_addr: issue reservation that marks a register busy.
module rv32i_regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 4,
  parameter int NWR = 2,
  parameter int ZERO_REG = 1,
  parameter int FWD_EN = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  output logic                 ready,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr
);
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);
  state_t state, state_n;
  logic [AW:0] clr_idx, clr_n;
  logic [NREGS-1:0] busy;
  logic [XLEN-1:0] regs [NREGS];
  assign ready = state == READY;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      clr_idx <= clr_n;
    end
  end
  always_comb begin
    state_n = state;
    clr_n = clr_idx;
    if (state == CLEAR) begin
      clr_n = clr_idx + 1'b1;
      state_n = clr_idx == LAST ? READY : CLEAR;
    end else if (clear_req) begin
      state_n = CLEAR;
      clr_n = '0;
    end
  end
  // Storage carries no reset; the clear engine zeroes it instead. Later ports win on address clashes.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      regs[clr_idx[AW-1:0]] <= '0;
    else
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*AW +: AW] == '0))
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
  end
  // Reservation is applied after write clears so a same-cycle reserve+write leaves the register busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy <= '0;
    else if (ready) begin
      if (clear_req)
        busy <= '0;
      else begin
        for (int w = 0; w < NWR; w++)
          if (wr_en[w] && !(ZERO_REG != 0 && wr_addr[w*AW +: AW] == '0))
            busy[wr_addr[w*AW +: AW]] <= 1'b0;
        if (rsv_en && !(ZERO_REG != 0 && rsv_addr == '0))
          busy[rsv_addr] <= 1'b1;
      end
    end
  end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_busy[p] = ready && busy[rd_addr[p*AW +: AW]];
      rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
      if (FWD_EN != 0)
        for (int w = 0; w < NWR; w++)
          if (wr_en[w] && wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])
            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
      if (!ready || (ZERO_REG != 0 && rd_addr[p*AW +: AW] == '0))
        rd_data[p*XLEN +: XLEN] = '0;
    end
  end
endmodule
